// File: rtl/muldiv_issue_ctrl_if.sv
// Decode/engine-facing signal bundle for muldiv_issue_ctrl.
// The mthi/mtlo write port exists only when MULDIV_MTHILO_EN is defined.
interface muldiv_issue_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic [1:0]       op_code;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_ready;
    logic             rd_valid;
    logic             rd_sel;
    logic [WIDTH-1:0] rd_data;
    logic             stall;
    logic             flush;
    logic             eng_start;
    logic [1:0]       eng_op;
    logic [WIDTH-1:0] eng_a;
    logic [WIDTH-1:0] eng_b;
    logic             eng_done;
    logic [WIDTH-1:0] eng_hi;
    logic [WIDTH-1:0] eng_lo;
    logic             dbz;
    logic             timeout_err;
`ifdef MULDIV_MTHILO_EN
    logic             wr_valid;
    logic             wr_sel;
    logic [WIDTH-1:0] wr_data;
`endif

    modport slave (
`ifdef MULDIV_MTHILO_EN
        input  wr_valid, wr_sel, wr_data,
`endif
        input  op_valid, op_code, op_a, op_b, rd_valid, rd_sel, flush,
        input  eng_done, eng_hi, eng_lo,
        output op_ready, rd_data, stall, eng_start, eng_op, eng_a, eng_b,
        output dbz, timeout_err
    );

    modport master (
`ifdef MULDIV_MTHILO_EN
        output wr_valid, wr_sel, wr_data,
`endif
        output op_valid, op_code, op_a, op_b, rd_valid, rd_sel, flush,
        output eng_done, eng_hi, eng_lo,
        input  op_ready, rd_data, stall, eng_start, eng_op, eng_a, eng_b,
        input  dbz, timeout_err
    );
endinterface

// File: rtl/muldiv_issue_ctrl.sv
// Mult/div issue controller: launches the iterative engine, owns HI/LO, stalls on hazards.
// Optional mthi/mtlo write port enabled by defining MULDIV_MTHILO_EN.
module muldiv_issue_ctrl #(
    parameter int WIDTH      = 32,
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input logic                clk,
    input logic                rst,
    muldiv_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DRAIN} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_CYCLES - 1);

    if (2 ** CNT_W <= MAX_CYCLES) begin : g_cnt_w_check
        $error("CNT_W too narrow to count MAX_CYCLES");
    end

    state_t           state;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [1:0]       eng_op;
    logic [WIDTH-1:0] eng_a;
    logic [WIDTH-1:0] eng_b;
    logic             eng_start;
    logic             dbz;
    logic             timeout_err;
    logic [CNT_W-1:0] count;
    logic             last_cycle;
    logic             wr_hold;

    function automatic logic is_dbz(input logic [1:0] code, input logic [WIDTH-1:0] divisor);
        return code[1] && (divisor == '0);
    endfunction

    assign last_cycle = (count == LAST_CNT);

`ifdef MULDIV_MTHILO_EN
    assign wr_hold = bus.wr_valid && (state != IDLE);
`else
    assign wr_hold = 1'b0;
`endif

    assign bus.op_ready    = (state == IDLE);
    assign bus.rd_data     = bus.rd_sel ? hi : lo;
    assign bus.stall       = (bus.rd_valid && state != IDLE) || (bus.op_valid && state != IDLE) || wr_hold;
    assign bus.eng_start   = eng_start;
    assign bus.eng_op      = eng_op;
    assign bus.eng_a       = eng_a;
    assign bus.eng_b       = eng_b;
    assign bus.dbz         = dbz;
    assign bus.timeout_err = timeout_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            hi          <= '0;
            lo          <= '0;
            eng_op      <= '0;
            eng_a       <= '0;
            eng_b       <= '0;
            eng_start   <= 1'b0;
            dbz         <= 1'b0;
            timeout_err <= 1'b0;
            count       <= '0;
        end else begin
            eng_start <= 1'b0;
            dbz       <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.op_valid && !bus.flush) begin
                        if (is_dbz(bus.op_code, bus.op_b)) begin
                            hi  <= bus.op_a;
                            lo  <= '1;
                            dbz <= 1'b1;
                        end else begin
                            eng_op    <= bus.op_code;
                            eng_a     <= bus.op_a;
                            eng_b     <= bus.op_b;
                            eng_start <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    count <= '0;
                    state <= bus.flush ? DRAIN : BUSY;
                end
                BUSY, DRAIN: begin
                    // A squashed op (DRAIN, or flush arriving with done) never reaches HI/LO.
                    count <= count + 1'b1;
                    if (bus.eng_done) begin
                        if (state == BUSY && !bus.flush) begin
                            hi <= bus.eng_hi;
                            lo <= bus.eng_lo;
                        end
                        state <= IDLE;
                    end else if (last_cycle) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else if (bus.flush) begin
                        state <= DRAIN;
                    end
                end
            endcase
`ifdef MULDIV_MTHILO_EN
            // Written last so it overrides a same-cycle dbz update of that register.
            if (state == IDLE && bus.wr_valid) begin
                if (bus.wr_sel) hi <= bus.wr_data;
                else            lo <= bus.wr_data;
            end
`endif
        end
    end
endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Bench for muldiv_issue_ctrl: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the controller.
module tb_muldiv_issue_ctrl;
    localparam int WIDTH      = 32;
    localparam int MAX_CYCLES = 40;
    localparam int CNT_W      = 6;

    logic clk;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    muldiv_issue_ctrl_if #(.WIDTH(WIDTH)) bus ();

    muldiv_issue_ctrl #(.WIDTH(WIDTH), .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: an engine operation is either absent, being launched, or in flight
    // for m_age engine cycles, possibly already squashed by a flush.
    bit          m_busy, m_launch, m_sq, m_terr, m_dbz;
    int          m_age;
    logic [31:0] m_hi, m_lo, m_ea, m_eb;
    logic [1:0]  m_eop;

    task automatic model_reset();
        m_busy = 0; m_launch = 0; m_sq = 0; m_terr = 0; m_dbz = 0; m_age = 0;
        m_hi = '0; m_lo = '0; m_ea = '0; m_eb = '0; m_eop = '0;
    endtask

    task automatic model_step();
        bit dbz_n    = 0;
        bit launch_n = 0;
        if (!m_busy) begin
            if (bus.op_valid && !bus.flush) begin
                if (bus.op_code[1] && bus.op_b == 32'd0) begin
                    m_hi  = bus.op_a;
                    m_lo  = 32'hFFFF_FFFF;
                    dbz_n = 1;
                end else begin
                    m_busy   = 1;
                    launch_n = 1;
                    m_eop    = bus.op_code;
                    m_ea     = bus.op_a;
                    m_eb     = bus.op_b;
                end
            end
`ifdef MULDIV_MTHILO_EN
            if (bus.wr_valid) begin
                if (bus.wr_sel) m_hi = bus.wr_data;
                else            m_lo = bus.wr_data;
            end
`endif
        end else if (m_launch) begin
            m_sq  = bus.flush;
            m_age = 0;
        end else begin
            m_age++;
            if (bus.eng_done) begin
                if (!m_sq && !bus.flush) begin
                    m_hi = bus.eng_hi;
                    m_lo = bus.eng_lo;
                end
                m_busy = 0;
            end else if (m_age == MAX_CYCLES) begin
                m_terr = 1;
                m_busy = 0;
            end else if (bus.flush) begin
                m_sq = 1;
            end
        end
        m_launch = launch_n;
        m_dbz    = dbz_n;
    endtask

    always @(negedge clk) begin
        logic exp_stall;
        if (rst) model_reset();
        exp_stall = (bus.rd_valid && m_busy) || (bus.op_valid && m_busy);
`ifdef MULDIV_MTHILO_EN
        exp_stall = exp_stall || (bus.wr_valid && m_busy);
`endif
        check("cyc op_ready",    32'(bus.op_ready),    32'(!m_busy));
        check("cyc stall",       32'(bus.stall),       32'(exp_stall));
        check("cyc rd_data",     bus.rd_data,          bus.rd_sel ? m_hi : m_lo);
        check("cyc eng_start",   32'(bus.eng_start),   32'(m_launch));
        check("cyc eng_op",      32'(bus.eng_op),      32'(m_eop));
        check("cyc eng_a",       bus.eng_a,            m_ea);
        check("cyc eng_b",       bus.eng_b,            m_eb);
        check("cyc dbz",         32'(bus.dbz),         32'(m_dbz));
        check("cyc timeout_err", 32'(bus.timeout_err), 32'(m_terr));
        if (!rst) model_step();
    end

    // Engine stand-in: eng_done arrives in the eng_lat-th cycle after the ISSUE cycle.
    logic [31:0] nxt_hi, nxt_lo;
    int          eng_lat;
    int          eng_left;
    bit          spur_en;

    initial begin
        eng_left     = 0;
        bus.eng_done = 1'b0;
        bus.eng_hi   = '0;
        bus.eng_lo   = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.eng_done = 1'b0;
            if (eng_left == 1) begin
                bus.eng_done = 1'b1;
                bus.eng_hi   = nxt_hi;
                bus.eng_lo   = nxt_lo;
                eng_left     = 0;
            end else if (eng_left > 1) begin
                eng_left--;
            end else if (spur_en && (!m_busy || m_launch) && $urandom_range(0, 7) == 0) begin
                bus.eng_done = 1'b1;
                bus.eng_hi   = $urandom;
                bus.eng_lo   = $urandom;
            end
            @(negedge clk);
            if (rst) eng_left = 0;
            else if (bus.eng_start) eng_left = eng_lat;
        end
    end

    initial begin
        int n;
        rst          = 1'b1;
        bus.op_valid = 1'b0;
        bus.op_code  = '0;
        bus.op_a     = '0;
        bus.op_b     = '0;
        bus.rd_valid = 1'b0;
        bus.rd_sel   = 1'b0;
        bus.flush    = 1'b0;
`ifdef MULDIV_MTHILO_EN
        bus.wr_valid = 1'b0;
        bus.wr_sel   = 1'b0;
        bus.wr_data  = '0;
`endif
        eng_lat = 1;
        nxt_hi  = '0;
        nxt_lo  = '0;
        spur_en = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset op_ready",    32'(bus.op_ready),    32'd1);
        check("reset eng_start",   32'(bus.eng_start),   32'd0);
        check("reset dbz",         32'(bus.dbz),         32'd0);
        check("reset timeout_err", 32'(bus.timeout_err), 32'd0);
        check("reset eng_a",       bus.eng_a,            32'd0);
        check("reset lo",          bus.rd_data,          32'd0);
        rst = 1'b0;

        // mult 7 * -3, engine takes 33 cycles, mflo waits behind it
        nxt_hi = 32'hFFFF_FFFF; nxt_lo = 32'hFFFF_FFEB; eng_lat = 33;
        bus.op_valid = 1'b1; bus.op_code = 2'b00; bus.op_a = 32'd7; bus.op_b = 32'hFFFF_FFFD;
        tick();
        bus.op_valid = 1'b0;
        check("mult eng_start",  32'(bus.eng_start), 32'd1);
        check("mult eng_a",      bus.eng_a,          32'd7);
        check("mult eng_b",      bus.eng_b,          32'hFFFF_FFFD);
        check("mult op_ready",   32'(bus.op_ready),  32'd0);
        tick();
        check("mult start pulse", 32'(bus.eng_start), 32'd0);
        bus.rd_valid = 1'b1; bus.rd_sel = 1'b0;
        #1;
        check("mult mflo stall", 32'(bus.stall), 32'd1);
        n = 1;
        while (!bus.op_ready && n < 60) begin tick(); n++; end
        check("mult latency", 32'(n), 32'd34);
        check("mult stall released", 32'(bus.stall), 32'd0);
        check("mult lo", bus.rd_data, 32'hFFFF_FFEB);
        bus.rd_sel = 1'b1;
        #1;
        check("mult hi", bus.rd_data, 32'hFFFF_FFFF);
        bus.rd_valid = 1'b0;

        // divu 100 / 0
        tick();
        bus.op_valid = 1'b1; bus.op_code = 2'b11; bus.op_a = 32'd100; bus.op_b = 32'd0;
        tick();
        bus.op_valid = 1'b0;
        check("dbz pulse",     32'(bus.dbz),       32'd1);
        check("dbz no start",  32'(bus.eng_start), 32'd0);
        check("dbz op_ready",  32'(bus.op_ready),  32'd1);
        bus.rd_sel = 1'b1;
        #1;
        check("dbz hi", bus.rd_data, 32'd100);
        bus.rd_sel = 1'b0;
        #1;
        check("dbz lo", bus.rd_data, 32'hFFFF_FFFF);
        tick();
        check("dbz one cycle", 32'(bus.dbz), 32'd0);

        // back-to-back divides: second request waits for the first to finish
        nxt_hi = 32'd1; nxt_lo = 32'd7; eng_lat = 10;
        bus.op_valid = 1'b1; bus.op_code = 2'b10; bus.op_a = 32'd50; bus.op_b = 32'd7;
        tick();
        bus.op_a = 32'd9; bus.op_b = 32'd2;
        #1;
        n = 0;
        while (!bus.op_ready && n < 60) begin
            check("b2b stall", 32'(bus.stall), 32'd1);
            tick();
            n++;
        end
        check("b2b first latency", 32'(n), 32'd11);
        check("b2b first lo", bus.rd_data, 32'd7);
        check("b2b accept stall", 32'(bus.stall), 32'd0);
        nxt_lo = 32'd4;
        tick();
        bus.op_valid = 1'b0;
        check("b2b second eng_a", bus.eng_a, 32'd9);
        check("b2b second eng_b", bus.eng_b, 32'd2);
        n = 0;
        while (!bus.op_ready && n < 60) begin tick(); n++; end
        check("b2b second lo", bus.rd_data, 32'd4);
        bus.rd_sel = 1'b1;
        #1;
        check("b2b second hi", bus.rd_data, 32'd1);
        bus.rd_sel = 1'b0;

        // flush at count 5; late result must be discarded
        nxt_hi = 32'h1234; nxt_lo = 32'h5678; eng_lat = 12;
        bus.op_valid = 1'b1; bus.op_code = 2'b00; bus.op_a = 32'd3; bus.op_b = 32'd5;
        tick();
        bus.op_valid = 1'b0;
        tick();
        n = 1;
        repeat (5) begin tick(); n++; end
        bus.flush = 1'b1;
        tick();
        n++;
        bus.flush = 1'b0;
        check("flush drain op_ready", 32'(bus.op_ready), 32'd0);
        while (!bus.op_ready && n < 60) begin tick(); n++; end
        check("flush ready after done", 32'(n), 32'd13);
        check("flush lo kept", bus.rd_data, 32'd4);
        bus.rd_sel = 1'b1;
        #1;
        check("flush hi kept", bus.rd_data, 32'd1);
        bus.rd_sel = 1'b0;

        // timeout: engine silent, error appears after 40 BUSY cycles
        eng_lat = 1000;
        bus.op_valid = 1'b1; bus.op_code = 2'b01; bus.op_a = 32'd5; bus.op_b = 32'd6;
        tick();
        bus.op_valid = 1'b0;
        check("timeout clear at issue", 32'(bus.timeout_err), 32'd0);
        n = 0;
        while (!bus.timeout_err && n < 60) begin tick(); n++; end
        check("timeout cycle", 32'(n), 32'd41);
        check("timeout idle", 32'(bus.op_ready), 32'd1);
        check("timeout hi/lo kept", bus.rd_data, 32'd4);
        repeat (3) tick();
        check("timeout sticky", 32'(bus.timeout_err), 32'd1);

        // asynchronous reset in the middle of BUSY
        bus.op_valid = 1'b1; bus.op_code = 2'b00; bus.op_a = 32'd2; bus.op_b = 32'd3;
        tick();
        bus.op_valid = 1'b0;
        repeat (4) tick();
        bus.rd_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst op_ready",    32'(bus.op_ready),    32'd1);
        check("arst stall",       32'(bus.stall),       32'd0);
        check("arst eng_a",       bus.eng_a,            32'd0);
        check("arst timeout_err", 32'(bus.timeout_err), 32'd0);
        check("arst lo",          bus.rd_data,          32'd0);
        bus.rd_sel = 1'b1;
        #1;
        check("arst hi",          bus.rd_data,          32'd0);
        bus.rd_valid = 1'b0;
        bus.rd_sel   = 1'b0;
        tick();
        rst = 1'b0;

        // random traffic against the model
        spur_en = 1;
        for (int i = 0; i < 3000; i++) begin
            nxt_hi       = $urandom;
            nxt_lo       = $urandom;
            eng_lat      = ($urandom_range(0, 4) == 0) ? int'($urandom_range(35, 45)) : int'($urandom_range(1, 20));
            bus.op_valid = ($urandom_range(0, 2) == 0);
            bus.op_code  = 2'($urandom_range(0, 3));
            bus.op_a     = $urandom;
            bus.op_b     = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            bus.rd_valid = $urandom_range(0, 1) == 1;
            bus.rd_sel   = $urandom_range(0, 1) == 1;
            bus.flush    = ($urandom_range(0, 15) == 0);
`ifdef MULDIV_MTHILO_EN
            bus.wr_valid = ($urandom_range(0, 7) == 0);
            bus.wr_sel   = $urandom_range(0, 1) == 1;
            bus.wr_data  = $urandom;
`endif
            tick();
        end
        bus.op_valid = 1'b0;
        bus.rd_valid = 1'b0;
        bus.flush    = 1'b0;
        spur_en      = 0;
        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
